a0_trace_buffer: RTL

//  Sits directly downstream of the CPU top and consumes its a0 output.
//  - Each cycle, detects when a0 changes value.
//  - Pushes every change, with a free-running cycle timestamp, into a FIFO.
//  - The FIFO is drained over a valid/ready handshake by the display/host side.

---
 rtl/a0_trace_buffer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/a0_trace_buffer.sv
// -----------------------------------------------------------------------------
// a0_trace_buffer
//
// Watches the CPU a0 register and records every change of value, tagged with a
// free-running cycle timestamp, into a small first-word-fall-through FIFO. A
// slower host/display side drains the FIFO over a valid/ready handshake. When
// the FIFO is full and nothing is popped, new changes are dropped and a sticky
// overflow flag is raised so the consumer knows the trace is incomplete.
//
// Ports
//   clk        in   clock, all state changes on posedge
//   rst        in   synchronous active-low reset
//   a0         in   CPU a0 value (DATA_WIDTH)
//   en         in   capture enable; when low a0 is ignored and prev_a0 holds
//   out_valid  out  head entry available
//   out_ready  in   consumer accepts the head entry this cycle
//   out_data   out  head entry a0 value (0 while empty)
//   out_ts     out  head entry timestamp (0 while empty)
//   count      out  number of stored entries, 0..DEPTH
//   full       out  count == DEPTH
//   overflow   out  sticky: at least one change was dropped
//   ovf_clr    in   clears overflow (a drop on the same edge wins)
// -----------------------------------------------------------------------------
module a0_trace_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      a0,
    input  logic                       en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [TS_WIDTH-1:0]        out_ts,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + TS_WIDTH;

    // State registers
    logic [TS_WIDTH-1:0]   ts_q,    ts_d;
    logic [DATA_WIDTH-1:0] prev_q,  prev_d;
    logic [PW-1:0]         wr_q,    wr_d;
    logic [PW-1:0]         rd_q,    rd_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q,   ovf_d;
    logic [EW-1:0]         mem_q [DEPTH];

    // Combinational control
    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  accept_s;
    logic                  drop_s;
    logic                  valid_s;
    logic [EW-1:0]         head_s;

    // Change detection, FIFO bookkeeping and next-state computation
    always_comb begin
        valid_s  = (count_q != {CW{1'b0}});
        full_s   = (count_q == CW'(DEPTH));
        push_s   = en && (a0 != prev_q);
        pop_s    = valid_s && out_ready;
        // When full, a simultaneous pop frees the slot the push needs.
        accept_s = push_s && (!full_s || pop_s);
        drop_s   = push_s && full_s && !pop_s;

        ts_d     = ts_q + TS_WIDTH'(1);

        if (en) begin
            prev_d = a0;
        end else begin
            prev_d = prev_q;
        end

        if (accept_s) begin
            wr_d = wr_q + PW'(1);
        end else begin
            wr_d = wr_q;
        end

        if (pop_s) begin
            rd_d = rd_q + PW'(1);
        end else begin
            rd_d = rd_q;
        end

        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over clear so a drop is never silently lost.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control/state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_q    <= {TS_WIDTH{1'b0}};
            prev_q  <= {DATA_WIDTH{1'b0}};
            wr_q    <= {PW{1'b0}};
            rd_q    <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            ts_q    <= ts_d;
            prev_q  <= prev_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (rst && accept_s) begin
            mem_q[wr_q] <= {a0, ts_q};
        end
    end

    // Head presentation: zeros while empty, otherwise the entry at rd_q
    always_comb begin
        head_s = mem_q[rd_q];
        if (valid_s) begin
            out_data = head_s[EW-1:TS_WIDTH];
            out_ts   = head_s[TS_WIDTH-1:0];
        end else begin
            out_data = {DATA_WIDTH{1'b0}};
            out_ts   = {TS_WIDTH{1'b0}};
        end
        out_valid = valid_s;
        count     = count_q;
        full      = full_s;
        overflow  = ovf_q;
    end

endmodule
